// File: rtl/sigma_pkg.sv
// sigma_pkg
//   Shared encodings for the multicycle controller: FSM state values, the
//   opcodes the controller supports, and the mux/select codes it drives
//   toward the datapath (ALU source, writeback source, ALU op class,
//   immediate format).
package sigma_pkg;

  typedef enum logic [3:0] {
    S_FETCH         = 4'd0,
    S_DECODE        = 4'd1,
    S_MEM_ADDR_COMP = 4'd2,
    S_MEM_WRITE     = 4'd3,
    S_EXEC_R_TYPE   = 4'd4,
    S_WB_R_TYPE     = 4'd5,
    S_EXEC_I_TYPE   = 4'd6,
    S_WB_I_TYPE     = 4'd7
  } state_t;

  localparam logic [6:0] OPCODE_STORE = 7'b0100011;
  localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
  localparam logic [6:0] OPCODE_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI   = 7'b0110111;

  localparam logic ALU_SRC_REG = 1'b0;
  localparam logic ALU_SRC_IMM = 1'b1;

  localparam logic MEM_TO_REG_ALU_RES  = 1'b0;
  localparam logic MEM_TO_REG_MEM_DATA = 1'b1;

  localparam logic [1:0] ALU_OP_TYPE_R_I = 2'b00;
  localparam logic [1:0] ALU_OP_TYPE_LSU = 2'b01;
  localparam logic [1:0] ALU_OP_TYPE_LUI = 2'b10;

  localparam logic [2:0] IMM_TYPE_NONE = 3'b000;
  localparam logic [2:0] IMM_TYPE_I    = 3'b001;
  localparam logic [2:0] IMM_TYPE_S    = 3'b010;
  localparam logic [2:0] IMM_TYPE_B    = 3'b011;
  localparam logic [2:0] IMM_TYPE_U    = 3'b100;
  localparam logic [2:0] IMM_TYPE_J    = 3'b101;

  // True for every opcode the decode state knows how to dispatch.
  function automatic logic is_supported(input logic [6:0] op);
    return (op == OPCODE_STORE) || (op == OPCODE_RTYPE) ||
           (op == OPCODE_IMM)   || (op == OPCODE_LUI);
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multicycle instruction sequencer: fetch, decode, then a short execute /
//   memory / writeback sequence for stores, R-type, I-type ALU and LUI.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   opcode[6:0]    instruction register opcode field
//   imem_ready     instruction read data valid this cycle
//   dmem_ready     data memory write accepted this cycle
//   imem_req       instruction fetch request
//   pc_write       PC <= PC+4 enable
//   ir_write       instruction register load enable
//   mem_write      data memory write strobe
//   reg_write      register file write enable
//   alu_src        ALU_SRC_REG / ALU_SRC_IMM
//   mem_to_reg     MEM_TO_REG_ALU_RES / MEM_TO_REG_MEM_DATA
//   alu_op_type    ALU_OP_TYPE_*
//   imm_type       IMM_TYPE_* for the sign extender
//   illegal_instr  one-cycle pulse after decoding an unsupported opcode
//   state_o        current FSM state (debug)
//
// state            | meaning
// -----------------+-----------------------------------------------
// S_FETCH          | request instruction, load IR/PC when ready
// S_DECODE         | dispatch on opcode; unsupported -> back to fetch
// S_MEM_ADDR_COMP  | store address = rs1 + S-immediate
// S_MEM_WRITE      | hold write strobe until memory accepts
// S_EXEC_R_TYPE    | register-register ALU operation
// S_WB_R_TYPE      | write ALU result to register file
// S_EXEC_I_TYPE    | register-immediate ALU operation or LUI
// S_WB_I_TYPE      | write ALU result to register file
module multicycle_ctrl
  import sigma_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic [1:0] alu_op_type,
  output logic [2:0] imm_type,
  output logic       illegal_instr,
  output logic [3:0] state_o
);

  state_t state_q;
  state_t state_d;
  logic   illegal_q;

  // State register and illegal-opcode flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= (state_q == S_DECODE) && !is_supported(opcode);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:
        state_d = imem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OPCODE_STORE: state_d = S_MEM_ADDR_COMP;
          OPCODE_RTYPE: state_d = S_EXEC_R_TYPE;
          OPCODE_IMM,
          OPCODE_LUI:   state_d = S_EXEC_I_TYPE;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR_COMP: state_d = S_MEM_WRITE;
      S_MEM_WRITE:     state_d = dmem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R_TYPE:   state_d = S_WB_R_TYPE;
      S_WB_R_TYPE:     state_d = S_FETCH;
      S_EXEC_I_TYPE:   state_d = S_WB_I_TYPE;
      S_WB_I_TYPE:     state_d = S_FETCH;
      // Unencoded values recover to fetch.
      default:         state_d = S_FETCH;
    endcase
  end

  // Output decode.
  always_comb begin
    imem_req    = 1'b0;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    alu_src     = ALU_SRC_REG;
    mem_to_reg  = MEM_TO_REG_ALU_RES;
    alu_op_type = ALU_OP_TYPE_R_I;
    imm_type    = IMM_TYPE_NONE;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        // Gated by rst_n so a ready instruction memory cannot advance the
        // PC or load the IR while the controller is held in reset.
        pc_write = imem_ready & rst_n;
        ir_write = imem_ready & rst_n;
      end
      S_MEM_ADDR_COMP: begin
        alu_src     = ALU_SRC_IMM;
        imm_type    = IMM_TYPE_S;
        alu_op_type = ALU_OP_TYPE_LSU;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        imm_type  = IMM_TYPE_S;
      end
      S_EXEC_R_TYPE: begin
        alu_src     = ALU_SRC_REG;
        alu_op_type = ALU_OP_TYPE_R_I;
      end
      S_WB_R_TYPE: begin
        reg_write  = 1'b1;
        mem_to_reg = MEM_TO_REG_ALU_RES;
      end
      S_EXEC_I_TYPE: begin
        alu_src = ALU_SRC_IMM;
        if (opcode == OPCODE_LUI) begin
          imm_type    = IMM_TYPE_U;
          alu_op_type = ALU_OP_TYPE_LUI;
        end else begin
          imm_type    = IMM_TYPE_I;
          alu_op_type = ALU_OP_TYPE_R_I;
        end
      end
      S_WB_I_TYPE: begin
        reg_write  = 1'b1;
        mem_to_reg = MEM_TO_REG_ALU_RES;
      end
      default: ;
    endcase
  end

  assign illegal_instr = illegal_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ILL  = 7'b1111111;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam int NVEC = 34;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       imem_ready;
  logic       dmem_ready;
  logic       imem_req, pc_write, ir_write, mem_write, reg_write;
  logic       alu_src, mem_to_reg, illegal_instr;
  logic [1:0] alu_op_type;
  logic [2:0] imm_type;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0]  op;
    logic        ir;
    logic        dr;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs [NVEC];

  multicycle_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .imem_req     (imem_req),
    .pc_write     (pc_write),
    .ir_write     (ir_write),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .alu_src      (alu_src),
    .mem_to_reg   (mem_to_reg),
    .alu_op_type  (alu_op_type),
    .imm_type     (imm_type),
    .illegal_instr(illegal_instr),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  // Packed output bundle:
  // {imem_req,pc_write,ir_write,mem_write,reg_write,alu_src,mem_to_reg,alu_op[1:0],imm[2:0],illegal,state[3:0]}
  function automatic logic [16:0] e(input logic [3:0] st, input logic ireq, input logic pcw,
                                    input logic irw, input logic mw, input logic rw,
                                    input logic asrc, input logic m2r, input logic [1:0] aop,
                                    input logic [2:0] imm, input logic ill);
    return {ireq, pcw, irw, mw, rw, asrc, m2r, aop, imm, ill, st};
  endfunction

  function automatic logic [16:0] actual();
    return {imem_req, pc_write, ir_write, mem_write, reg_write, alu_src, mem_to_reg,
            alu_op_type, imm_type, illegal_instr, state_o};
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ADDI
    vecs[0]  = '{OP_ADDI, 1'b1, 1'b0, e(0, 1,1,1, 0,0, 0,0, 2'd0, 3'd0, 0)};
    vecs[1]  = '{OP_ADDI, 1'b1, 1'b0, e(1, 0,0,0, 0,0, 0,0, 2'd0, 3'd0, 0)};
    vecs[2]  = '{OP_ADDI, 1'b1, 1'b0, e(6, 0,0,0, 0,0, 1,0, 2'd0, 3'd1, 0)};
    vecs[3]  = '{OP_ADDI, 1'b1, 1'b0, e(7, 0,0,0, 0,1, 0,0, 2'd0, 3'd0, 0)};
    // SW with three wait states
    vecs[4]  = '{OP_SW,   1'b1, 1'b0, e(0, 1,1,1, 0,0, 0,0, 2'd0, 3'd0, 0)};
    vecs[5]  = '{OP_SW,   1'b1, 1'b0, e(1, 0,0,0, 0,0, 0,0, 2'd0, 3'd0, 0)};
    vecs[6]  = '{OP_SW,   1'b1, 1'b0, e(2, 0,0,0, 0,0, 1,0, 2'd1, 3'd2, 0)};
    vecs[7]  = '{OP_SW,   1'b1, 1'b0, e(3, 0,0,0, 1,0, 0,0, 2'd0, 3'd2, 0)};
    vecs[8]  = '{OP_SW,   1'b1, 1'b0, e(3, 0,0,0, 1,0, 0,0, 2'd0, 3'd2, 0)};
    vecs[9]  = '{OP_SW,   1'b1, 1'b0, e(3, 0,0,0, 1,0, 0,0, 2'd0, 3'd2, 0)};
    vecs[10] = '{OP_SW,   1'b1, 1'b1, e(3, 0,0,0, 1,0, 0,0, 2'd0, 3'd2, 0)};
    // LUI
    vecs[11] = '{OP_LUI,  1'b1, 1'b0, e(0, 1,1,1, 0,0, 0,0, 2'd0, 3'd0, 0)};
    vecs[12] = '{OP_LUI,  1'b1, 1'b0, e(1, 0,0,0, 0,0, 0,0, 2'd0, 3'd0, 0)};
    vecs[13] = '{OP_LUI,  1'b1, 1'b0, e(6, 0,0,0, 0,0, 1,0, 2'd2, 3'd4, 0)};
    vecs[14] = '{OP_LUI,  1'b1, 1'b0, e(7, 0,0,0, 0,1, 0,0, 2'd0, 3'd0, 0)};
    // R-type
    vecs[15] = '{OP_R,    1'b1, 1'b0, e(0, 1,1,1, 0,0, 0,0, 2'd0, 3'd0, 0)};
    vecs[16] = '{OP_R,    1'b1, 1'b0, e(1, 0,0,0, 0,0, 0,0, 2'd0, 3'd0, 0)};
    vecs[17] = '{OP_R,    1'b1, 1'b0, e(4, 0,0,0, 0,0, 0,0, 2'd0, 3'd0, 0)};
    vecs[18] = '{OP_R,    1'b1, 1'b0, e(5, 0,0,0, 0,1, 0,0, 2'd0, 3'd0, 0)};
    // Illegal opcode, then five fetch wait states
    vecs[19] = '{OP_ILL,  1'b1, 1'b0, e(0, 1,1,1, 0,0, 0,0, 2'd0, 3'd0, 0)};
    vecs[20] = '{OP_ILL,  1'b1, 1'b0, e(1, 0,0,0, 0,0, 0,0, 2'd0, 3'd0, 0)};
    vecs[21] = '{OP_ADDI, 1'b0, 1'b0, e(0, 1,0,0, 0,0, 0,0, 2'd0, 3'd0, 1)};
    vecs[22] = '{OP_ADDI, 1'b0, 1'b0, e(0, 1,0,0, 0,0, 0,0, 2'd0, 3'd0, 0)};
    vecs[23] = '{OP_ADDI, 1'b0, 1'b0, e(0, 1,0,0, 0,0, 0,0, 2'd0, 3'd0, 0)};
    vecs[24] = '{OP_ADDI, 1'b0, 1'b0, e(0, 1,0,0, 0,0, 0,0, 2'd0, 3'd0, 0)};
    vecs[25] = '{OP_ADDI, 1'b0, 1'b0, e(0, 1,0,0, 0,0, 0,0, 2'd0, 3'd0, 0)};
    vecs[26] = '{OP_ADDI, 1'b1, 1'b0, e(0, 1,1,1, 0,0, 0,0, 2'd0, 3'd0, 0)};
    vecs[27] = '{OP_ADDI, 1'b1, 1'b0, e(1, 0,0,0, 0,0, 0,0, 2'd0, 3'd0, 0)};
    vecs[28] = '{OP_ADDI, 1'b1, 1'b0, e(6, 0,0,0, 0,0, 1,0, 2'd0, 3'd1, 0)};
    vecs[29] = '{OP_ADDI, 1'b1, 1'b0, e(7, 0,0,0, 0,1, 0,0, 2'd0, 3'd0, 0)};
    // Load is not supported by this controller
    vecs[30] = '{OP_LD,   1'b1, 1'b0, e(0, 1,1,1, 0,0, 0,0, 2'd0, 3'd0, 0)};
    vecs[31] = '{OP_LD,   1'b1, 1'b0, e(1, 0,0,0, 0,0, 0,0, 2'd0, 3'd0, 0)};
    vecs[32] = '{OP_ADDI, 1'b1, 1'b0, e(0, 1,1,1, 0,0, 0,0, 2'd0, 3'd0, 1)};
    vecs[33] = '{OP_ADDI, 1'b1, 1'b0, e(1, 0,0,0, 0,0, 0,0, 2'd0, 3'd0, 0)};

    // Reset state, with a ready instruction memory that must be ignored
    rst_n      = 1'b0;
    opcode     = OP_ADDI;
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    #3;
    check("reset_async", actual(), e(0, 1,0,0, 0,0, 0,0, 2'd0, 3'd0, 0));
    tick();
    tick();
    check("reset_held", actual(), e(0, 1,0,0, 0,0, 0,0, 2'd0, 3'd0, 0));

    // Release with imem_ready low: no transition until it rises
    imem_ready = 1'b0;
    rst_n      = 1'b1;
    tick();
    tick();
    check("release_wait", actual(), e(0, 1,0,0, 0,0, 0,0, 2'd0, 3'd0, 0));

    for (int i = 0; i < NVEC; i++) begin
      opcode     = vecs[i].op;
      imem_ready = vecs[i].ir;
      dmem_ready = vecs[i].dr;
      @(negedge clk);
      check($sformatf("vec%0d", i), actual(), vecs[i].exp);
      tick();
    end

    // Reset dropped during a stalled store write
    rst_n      = 1'b0;
    #2;
    rst_n      = 1'b1;
    opcode     = OP_SW;
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("sw_stalled", actual(), e(3, 0,0,0, 1,0, 0,0, 2'd0, 3'd2, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_write", actual(), e(0, 1,0,0, 0,0, 0,0, 2'd0, 3'd0, 0));
    tick();
    tick();
    check("rst_mid_hold", actual(), e(0, 1,0,0, 0,0, 0,0, 2'd0, 3'd0, 0));
    imem_ready = 1'b0;
    rst_n      = 1'b1;
    tick();
    check("post_rst_wait", actual(), e(0, 1,0,0, 0,0, 0,0, 2'd0, 3'd0, 0));
    opcode     = OP_ADDI;
    imem_ready = 1'b1;
    tick();
    check("post_rst_first", actual(), e(1, 0,0,0, 0,0, 0,0, 2'd0, 3'd0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
